// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam logic [3:0] AMP_WORD = 4'b1111;

endpackage

// File: rtl/arb_perfcnt.sv
// Three free-running 32-bit event counters for the memory arbiter (built only with ARB_PERF_EN).
module arb_perfcnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        inc_d,
    input  logic        inc_conf,
    output logic [31:0] perf_i_cnt,
    output logic [31:0] perf_d_cnt,
    output logic [31:0] perf_conf_cnt
);

    logic [31:0] i_cnt_q, i_cnt_d;
    logic [31:0] d_cnt_q, d_cnt_d;
    logic [31:0] conf_cnt_q, conf_cnt_d;

    always_comb begin
        i_cnt_d    = i_cnt_q + {31'd0, inc_i};
        d_cnt_d    = d_cnt_q + {31'd0, inc_d};
        conf_cnt_d = conf_cnt_q + {31'd0, inc_conf};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
            conf_cnt_q <= '0;
        end else begin
            i_cnt_q    <= i_cnt_d;
            d_cnt_q    <= d_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign perf_i_cnt    = i_cnt_q;
    assign perf_d_cnt    = d_cnt_q;
    assign perf_conf_cnt = conf_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory, one transaction at a time.
// Define ARB_PERF_EN to add issue/conflict performance counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_amp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_amp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stallF,
    output logic              stallM
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_conf_cnt
`endif
);

    arb_state_e        state_q, state_d;
    logic              issue_i, issue_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_amp_q, mem_amp_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_amp_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_amp_q   <= mem_amp_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // On completion only the other requester is considered; the owner's req is still its old one.
    always_comb begin
        state_d = state_q;
        issue_i = 1'b0;
        issue_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_req) begin
                    issue_d = 1'b1;
                end else if (i_req) begin
                    issue_i = 1'b1;
                end
            end
            ARB_BUSY_I: begin
                if (mem_rvalid) begin
                    if (d_req) begin
                        issue_d = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_BUSY_D: begin
                if (mem_rvalid) begin
                    if (i_req) begin
                        issue_i = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (issue_d) begin
            state_d = ARB_BUSY_D;
        end else if (issue_i) begin
            state_d = ARB_BUSY_I;
        end
    end

    always_comb begin
        i_rvalid    = (state_q == ARB_BUSY_I) && mem_rvalid;
        d_rvalid    = (state_q == ARB_BUSY_D) && mem_rvalid;
        i_rdata     = mem_rdata;
        d_rdata     = mem_rdata;
        stallF      = i_req && !i_rvalid;
        stallM      = d_req && !d_rvalid;
        mem_req_d   = issue_i || issue_d;
        mem_we_d    = mem_we_q;
        mem_amp_d   = mem_amp_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (issue_d) begin
            mem_we_d    = d_we;
            mem_amp_d   = d_amp;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (issue_i) begin
            mem_we_d    = 1'b0;
            mem_amp_d   = AMP_WORD;
            mem_addr_d  = i_addr;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_amp   = mem_amp_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ARB_PERF_EN
    arb_perfcnt u_perfcnt (
        .clk           (clk),
        .reset         (reset),
        .inc_i         (issue_i),
        .inc_d         (issue_d),
        .inc_conf      (i_req && d_req && !i_rvalid && !d_rvalid),
        .perf_i_cnt    (perf_i_cnt),
        .perf_d_cnt    (perf_d_cnt),
        .perf_conf_cnt (perf_conf_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs. a
// transaction-level model. Define ARB_PERF_EN to also check the performance counters.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_amp = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_amp;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stallF;
    logic        stallM;
`ifdef ARB_PERF_EN
    logic [31:0] perf_i_cnt, perf_d_cnt, perf_conf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_amp      (d_amp),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_amp    (mem_amp),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stallF     (stallF),
        .stallM     (stallM)
`ifdef ARB_PERF_EN
        ,
        .perf_i_cnt    (perf_i_cnt),
        .perf_d_cnt    (perf_d_cnt),
        .perf_conf_cnt (perf_conf_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the memory, and what was last issued.
    int          m_owner = 0;  // 0 none, 1 fetch, 2 data
    logic        m_req = 1'b0, m_we = 1'b0;
    logic [3:0]  m_amp = '0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] m_pi = '0, m_pd = '0, m_pc = '0;
    int          i_wait = 0, d_wait = 0;
    bit          done_i, done_d, g_i, g_d;
    bit          i_ack = 1'b0, d_ack = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            i_ack = i_rvalid;
            d_ack = d_rvalid;
            if (!reset) begin
                chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
                chk("rst_mem_addr", mem_addr, 32'd0);
                chk("rst_mem_payload", {27'd0, mem_we, mem_amp}, 32'd0);
                chk("rst_mem_wdata", mem_wdata, 32'd0);
                chk("rst_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
                m_owner = 0; m_req = 0; m_we = 0; m_amp = '0; m_addr = '0; m_wdata = '0;
                m_pi = '0; m_pd = '0; m_pc = '0; i_wait = 0; d_wait = 0;
            end else begin
                done_i = (m_owner == 1) && mem_rvalid;
                done_d = (m_owner == 2) && mem_rvalid;
                chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, done_i});
                chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, done_d});
                chk("stallF", {31'd0, stallF}, {31'd0, i_req && !done_i});
                chk("stallM", {31'd0, stallM}, {31'd0, d_req && !done_d});
                if (done_i) chk("i_rdata", i_rdata, mem_rdata);
                if (done_d) chk("d_rdata", d_rdata, mem_rdata);
                chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we_amp", {27'd0, mem_we, mem_amp}, {27'd0, m_we, m_amp});
                chk("mem_wdata", mem_wdata, m_wdata);
`ifdef ARB_PERF_EN
                chk("perf_i", perf_i_cnt, m_pi);
                chk("perf_d", perf_d_cnt, m_pd);
                chk("perf_conf", perf_conf_cnt, m_pc);
`endif
                if (i_req && d_req && !done_i && !done_d) m_pc++;
                // Memory is free when idle or finishing; the finisher cannot win this cycle.
                g_d = d_req && (m_owner == 0 || done_i);
                g_i = i_req && !g_d && (m_owner == 0 || done_d);
                if (g_d && i_req && !done_i) begin
                    i_wait++;
                    chk("fetch_waits_le_1", i_wait, (i_wait <= 1) ? i_wait : 1);
                end
                if (g_i && d_req && !done_d) begin
                    d_wait++;
                    chk("data_waits_le_1", d_wait, (d_wait <= 1) ? d_wait : 1);
                end
                m_req = g_i || g_d;
                if (g_d) begin
                    m_owner = 2; d_wait = 0; m_pd++;
                    m_we = d_we; m_amp = d_amp; m_addr = d_addr; m_wdata = d_wdata;
                end else if (g_i) begin
                    m_owner = 1; i_wait = 0; m_pi++;
                    m_we = 1'b0; m_amp = 4'hF; m_addr = i_addr;
                end else if (done_i || done_d) begin
                    m_owner = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [31:0] seq [4];
    int          n_iss;
    logic        last_req;
    bit          pend;
    int          lat;

    initial begin
        // Reset held with a stray completion.
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        smp();
        chk("reset_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_mem_amp", {28'd0, mem_amp}, 32'd0);
        cyc(); mem_rvalid = 1'b0; reset = 1'b1;

        // Single fetch, memory answering two cycles after mem_req.
        cyc(); i_req = 1'b1; i_addr = 32'h40;
        smp(); chk("fetch_c0_stall", {31'd0, stallF}, 32'd1);
        chk("fetch_c0_noreq", {31'd0, mem_req}, 32'd0);
        cyc(); smp();
        chk("fetch_c1_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_c1_addr", mem_addr, 32'h40);
        chk("fetch_c1_we_amp", {27'd0, mem_we, mem_amp}, 32'h0F);
        cyc(); smp();
        chk("fetch_c2_req_low", {31'd0, mem_req}, 32'd0);
        chk("fetch_c2_stall", {31'd0, stallF}, 32'd1);
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        smp();
        chk("fetch_c3_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("fetch_c3_rdata", i_rdata, 32'h0050_0093);
        chk("fetch_c3_nostall", {31'd0, stallF}, 32'd0);
        cyc(); mem_rvalid = 1'b0; i_req = 1'b0;

        // Conflict: store wins, fetch follows the cycle after d_rvalid.
        cyc(); i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_amp = 4'b0011;
        cyc(); smp();
        chk("conf_d_req", {31'd0, mem_req}, 32'd1);
        chk("conf_d_addr", mem_addr, 32'h100);
        chk("conf_d_we_amp", {27'd0, mem_we, mem_amp}, 32'h13);
        chk("conf_d_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); mem_rvalid = 1'b1;
        smp();
        chk("conf_d_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'd2);
        chk("conf_stalls", {30'd0, stallF, stallM}, 32'd2);
        cyc(); mem_rvalid = 1'b0; d_req = 1'b0;
        smp();
        chk("conf_i_req", {31'd0, mem_req}, 32'd1);
        chk("conf_i_addr", mem_addr, 32'h80);
        chk("conf_i_we_amp", {27'd0, mem_we, mem_amp}, 32'h0F);
        cyc(); mem_rvalid = 1'b1;
        smp(); chk("conf_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        cyc(); mem_rvalid = 1'b0; i_req = 1'b0;
        smp();
`ifdef ARB_PERF_EN
        chk("perf_lit_i", perf_i_cnt, 32'd2);
        chk("perf_lit_d", perf_d_cnt, 32'd1);
        chk("perf_lit_conf", perf_conf_cnt, 32'd2);
`endif

        // Reset while a load is in flight; its late completion must be dropped.
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_amp = 4'hF;
        cyc(); smp(); chk("midrst_issue", {31'd0, mem_req}, 32'd1);
        cyc(); reset = 1'b0; d_req = 1'b0;
        smp(); chk("midrst_addr_clr", mem_addr, 32'd0);
        cyc(); reset = 1'b1;
        cyc(); mem_rvalid = 1'b1;
        smp(); chk("midrst_stale", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        cyc(); mem_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h44;
        cyc(); smp();
        chk("midrst_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("midrst_fetch_addr", mem_addr, 32'h44);
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
        smp(); chk("midrst_fetch_rv", {31'd0, i_rvalid}, 32'd1);
        cyc(); mem_rvalid = 1'b0; i_req = 1'b0;

        // Spurious completion in idle.
        cyc(); mem_rvalid = 1'b1;
        smp(); chk("spurious_rv", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        cyc(); mem_rvalid = 1'b0;
        smp(); chk("spurious_noissue", {31'd0, mem_req}, 32'd0);

        // Both held continuously: owners must alternate D, I, D, I.
        cyc(); i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_amp = 4'hF;
        n_iss = 0; last_req = 1'b0;
        for (int c = 0; c < 14; c++) begin
            smp();
            if (mem_req) begin
                if (n_iss < 4) seq[n_iss] = mem_addr;
                n_iss++;
            end
            last_req = mem_req;
            cyc(); mem_rvalid = last_req;
        end
        chk("alt_count_ge4", (n_iss >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (n_iss >= 4) begin
            chk("alt_0_d", seq[0], 32'h2000);
            chk("alt_1_i", seq[1], 32'h1000);
            chk("alt_2_d", seq[2], 32'h2000);
            chk("alt_3_i", seq[3], 32'h1000);
        end
        i_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0; reset = 1'b0;
        cyc(); reset = 1'b1;

        // Randomized traffic with variable memory latency, stray completions and resets.
        pend = 1'b0; lat = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            reset = 1'b1;
            mem_rvalid = 1'b0;
            if (pend) begin
                if (lat == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = $urandom; pend = 1'b0;
                end else begin
                    lat--;
                end
            end else if (!mem_req && m_owner == 0 && $urandom_range(0, 9) == 0) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end
            if (mem_req) begin
                pend = 1'b1; lat = $urandom_range(0, 2);
            end
            if (!i_req || i_ack) begin
                i_req = ($urandom_range(0, 2) != 0);
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req || d_ack) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = 1'($urandom_range(0, 1));
                d_amp = 4'($urandom_range(0, 15));
                d_addr = $urandom;
                d_wdata = $urandom;
            end
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0; i_req = 1'b0; d_req = 1'b0; pend = 1'b0; mem_rvalid = 1'b0;
            end
        end
        cyc(); i_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0;
        smp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one single-port unified memory between the pipeline's instruction-fetch port and its data-access port. It serialises one outstanding memory transaction at a time and routes each response back to its owner. It raises stall indications for the fetch and memory stages while their requests are pending. It sits between the datapath's fetch/memory-stage interfaces and the memory model.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_rvalid.
- i_addr  in  ADDR_W  fetch address.
- i_rvalid  out  1  fetch response valid, one cycle.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held with its payload until d_rvalid.
- d_we  in  1  1 = store, 0 = load.
- d_amp  in  4  byte-enable access pattern.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rvalid  out  1  data response or store ack, one cycle.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request pulse, registered.
- mem_we  out  1  registered.
- mem_amp  out  4  registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_rvalid  in  1  memory completion, for both reads and write acks.
- mem_rdata  in  DATA_W  memory read data.
- stallF  out  1  i_req & ~i_rvalid.
- stallM  out  1  d_req & ~d_rvalid.
- Under ARB_PERF_EN only: perf_i_cnt, perf_d_cnt, perf_conf_cnt  out  32 each.

## Operation
- States: IDLE, BUSY_I, BUSY_D. The owner is implied by the state.
- IDLE:
  - d_req takes priority over i_req.
  - A granted request goes to BUSY_D or BUSY_I, and its payload is registered onto mem_*.
  - Fetch payload is mem_we = 0, mem_amp = 4'b1111.
- BUSY_x without mem_rvalid: hold state. mem_req is low and the mem_* payload is held.
- BUSY_x with mem_rvalid:
  - Assert x_rvalid combinationally; x_rdata = mem_rdata.
  - In the same cycle, arbitrate only the other requester. If it is requesting, issue it and move to its BUSY state; otherwise go to IDLE.
  - The completing owner's req in this cycle is its old request and is ignored.
- mem_rvalid in IDLE is ignored; neither rvalid is raised.
- i_rdata and d_rdata both mirror mem_rdata. Only the rvalid lines qualify them.
- Each requester is guaranteed service within one transaction of the other, because completions alternate.

## Timing
- Reset (asynchronous, active low):
  - State goes to IDLE; mem_req, mem_we, mem_amp, mem_addr and mem_wdata go to 0; perf counters go to 0.
  - i_rvalid and d_rvalid are 0 because the state is IDLE.
  - An in-flight transaction is abandoned. Its later mem_rvalid arrives in IDLE and is dropped.
- Issue latency: request seen in IDLE at cycle N → mem_req high in cycle N+1 for exactly one cycle.
- Response: x_rvalid is in the same cycle as mem_rvalid (zero added latency). Memory latency is arbitrary, minimum 1 cycle after mem_req.
- Back-to-back: the other requester's mem_req appears in the cycle after the completing mem_rvalid.
- Simultaneous i_req and d_req in IDLE: D is issued. I is issued in the cycle after D's mem_rvalid.
- stallF and stallM are combinational and deassert in the rvalid cycle.

## Configuration
- ARB_PERF_EN defined:
  - perf_i_cnt and perf_d_cnt count issued fetch and data transactions.
  - perf_conf_cnt counts cycles in which i_req and d_req are both high and no rvalid is asserted.
  - All three wrap at 2^32 and clear only on reset.
- ARB_PERF_EN undefined: the counter ports and logic are absent, and arbitration behaviour is identical.

## Structure
- Shared defines file holds the state encodings ARB_IDLE=2'd0, ARB_BUSY_I=2'd1, ARB_BUSY_D=2'd2, and the constant AMP_WORD=4'b1111.
- One sub-module, arb_perfcnt (three 32-bit counters), is instantiated only under ARB_PERF_EN. Everything else lives in mem_arbiter.

## Test plan
- Reset: hold reset low with mem_rvalid pulsed → all mem_* outputs are 0, state is IDLE, and no rvalid is raised.
- Single fetch: i_req=1, i_addr=0x40 in cycle 0; memory returns 0x00500093 two cycles after mem_req → mem_req high in cycle 1 with addr 0x40, we=0, amp=1111; i_rvalid in cycle 3 with i_rdata=0x00500093; stallF high in cycles 0–2.
- Conflict: i_req=1 and d_req=1 (store to 0x100, wdata 0xDEADBEEF, amp 0011) in the same IDLE cycle → data is issued first with we=1; fetch mem_req appears in the cycle after d_rvalid; perf_conf_cnt increments for each overlapping cycle (ARB_PERF_EN).
- Alternation: both requesters held continuously → mem_req owners alternate D, I, D, I, and no requester waits more than one transaction.
- Reset mid-transaction: assert reset while in BUSY_D, release, then pulse mem_rvalid → d_rvalid stays 0, state stays IDLE, and a fresh i_req is issued normally.
- Spurious completion: mem_rvalid=1 while in IDLE with no request → no rvalid, and no state change.
